alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter that time-shares one combinational ALU between the core control unit and the DDR address generator.
// Optional zero/not-zero-or-one flags on the result are compiled in with `define ALU_FLAGS_EN.
module alu_share_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int A_W           = 12,
   parameter int D_W           = 19
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0,
   input  logic [2:0]     op0,
   input  logic [A_W-1:0] a0,
   input  logic [D_W-1:0] b0,
   input  logic           req1,
   input  logic [2:0]     op1,
   input  logic [A_W-1:0] a1,
   input  logic [D_W-1:0] b1,
   output logic           gnt0,
   output logic           gnt1,
   output logic           done0,
   output logic           done1,
   output logic [D_W-1:0] res,
   output logic           busy,
   output logic [A_W-1:0] alu_a,
   output logic [D_W-1:0] alu_b,
   output logic [2:0]     alu_op,
   input  logic [D_W-1:0] alu_c
`ifdef ALU_FLAGS_EN
   ,
   output logic           z,
   output logic           z1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t         state;
   logic           last_grant;
   logic           any_req;
   logic           win_port;
   logic [2:0]     win_op;
   logic [A_W-1:0] win_a;
   logic [D_W-1:0] win_b;

   // Winner selection; a lone request always wins regardless of mode.
   always_comb begin
      any_req  = req0 | req1;
      win_port = 1'b0;
      if (PRIORITY_MODE == 1)
         win_port = ~req0;
      else if (req0 && req1)
         win_port = ~last_grant;
      else
         win_port = ~req0;
      win_op = win_port ? op1 : op0;
      win_a  = win_port ? a1  : a0;
      win_b  = win_port ? b1  : b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         busy       <= 1'b0;
         res        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
`ifdef ALU_FLAGS_EN
         z          <= 1'b0;
         z1         <= 1'b1;
`endif
      end else begin
         case (state)
            EXEC: begin
               res   <= alu_c;
               done0 <= ~last_grant;
               done1 <= last_grant;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b1;
               state <= DONE;
`ifdef ALU_FLAGS_EN
               z     <= (alu_c == '0);
               z1    <= (alu_c != '0) && (alu_c != D_W'(1));
`endif
            end
            // IDLE and DONE arbitrate identically, giving back-to-back grants.
            default: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               if (any_req) begin
                  gnt0       <= ~win_port;
                  gnt1       <= win_port;
                  last_grant <= win_port;
                  alu_op     <= win_op;
                  alu_a      <= win_a;
                  alu_b      <= win_b;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end else begin
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table-driven single transactions plus contention and reset sequences.
// One instance runs round-robin (scoreboarded), a second runs fixed priority.
module tb_alu_share_arbiter;

   localparam int A_W = 12;
   localparam int D_W = 19;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0, req1, q_req0, q_req1;
   logic [2:0]     op0, op1, q_op0, q_op1;
   logic [A_W-1:0] a0, a1, q_a0, q_a1;
   logic [D_W-1:0] b0, b1, q_b0, q_b1;
   logic           gnt0, gnt1, done0, done1, busy;
   logic           q_gnt0, q_gnt1, q_done0, q_done1, q_busy;
   logic [D_W-1:0] res, q_res, alu_b, q_alu_b, alu_c, q_alu_c;
   logic [A_W-1:0] alu_a, q_alu_a;
   logic [2:0]     alu_op, q_alu_op;
`ifdef ALU_FLAGS_EN
   logic           z, z1, q_z, q_z1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic           port;
      logic [D_W-1:0] res;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic           port;
      logic [2:0]     op;
      logic [A_W-1:0] a;
      logic [D_W-1:0] b;
      logic [D_W-1:0] exp;
   } vec_t;
   vec_t vecs[11];

   always #5 clk = ~clk;

   // Reference ALU: B-centric ops, SUB is B-A, DIV16 shifts A.
   function automatic logic [D_W-1:0] alu_f(input logic [2:0] op, input logic [A_W-1:0] a,
                                            input logic [D_W-1:0] b);
      logic [D_W-1:0] ax;
      ax = {{(D_W-A_W){1'b0}}, a};
      case (op)
         3'd0:    return b + ax;
         3'd1:    return ax >> 4;
         3'd2:    return b - ax;
         3'd3:    return b + D_W'(2);
         3'd4:    return b + D_W'(1);
         3'd5:    return b - D_W'(1);
         3'd6:    return b << 1;
         default: return b << 2;
      endcase
   endfunction

   assign alu_c   = alu_f(alu_op, alu_a, alu_b);
   assign q_alu_c = alu_f(q_alu_op, q_alu_a, q_alu_b);

   alu_share_arbiter #(.PRIORITY_MODE(0), .A_W(A_W), .D_W(D_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .res(res), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
`ifdef ALU_FLAGS_EN
      , .z(z), .z1(z1)
`endif
   );

   alu_share_arbiter #(.PRIORITY_MODE(1), .A_W(A_W), .D_W(D_W)) dut_p (
      .clk(clk), .rst(rst),
      .req0(q_req0), .op0(q_op0), .a0(q_a0), .b0(q_b0),
      .req1(q_req1), .op1(q_op1), .a1(q_a1), .b1(q_b1),
      .gnt0(q_gnt0), .gnt1(q_gnt1), .done0(q_done0), .done1(q_done1),
      .res(q_res), .busy(q_busy),
      .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op(q_alu_op), .alu_c(q_alu_c)
`ifdef ALU_FLAGS_EN
      , .z(q_z), .z1(q_z1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every completion pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && (done0 || done1)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'(done1), 32'hDEAD);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_port", {31'b0, done1}, {31'b0, e.port});
            chk("done_both", {31'b0, done0 & done1}, 32'd0);
            chk("res", 32'(res), 32'(e.res));
`ifdef ALU_FLAGS_EN
            chk("z", 32'(z), 32'(e.res == '0));
            chk("z1", 32'(z1), 32'(e.res > D_W'(1)));
`endif
         end
      end
   end

   task automatic do_txn(input logic port, input logic [2:0] op, input logic [A_W-1:0] a,
                         input logic [D_W-1:0] b, input logic [D_W-1:0] exp);
      int gc;
      exp_t e;
      @(posedge clk); #1;
      if (port) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      else      begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      e.port = port;
      e.res  = exp;
      sbq.push_back(e);
      gc = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (port ? gnt1 : gnt0) begin gc = c; break; end
      end
      chk("gnt_latency", gc, 32'd1);
      chk("gnt_other", 32'(port ? gnt0 : gnt1), 32'd0);
      @(posedge clk); #1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(port ? done1 : done0), 32'd1);
      chk("busy_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("alu_hold", {17'b0, alu_op, alu_a}, {17'b0, op, a});
      chk("alu_b_hold", 32'(alu_b), 32'(b));
   endtask

   initial begin : main
      int gc, g0c, g1c, ng0, ng1, nd0;
      exp_t e;
      vecs[0]  = '{1'b0, 3'd0, 12'd5,     19'd0,       19'd15};
      vecs[1]  = '{1'b1, 3'd2, 12'd3,     19'd1,       19'h7FFFE};
      vecs[2]  = '{1'b0, 3'd7, 12'd0,     19'h7FFFF,   19'h7FFFC};
      vecs[3]  = '{1'b1, 3'd1, 12'd256,   19'd0,       19'd16};
      vecs[4]  = '{1'b0, 3'd3, 12'd0,     19'h7FFFF,   19'd1};
      vecs[5]  = '{1'b1, 3'd4, 12'd0,     19'd1,       19'd2};
      vecs[6]  = '{1'b0, 3'd5, 12'd0,     19'd0,       19'h7FFFF};
      vecs[7]  = '{1'b1, 3'd6, 12'd0,     19'h40000,   19'd0};
      vecs[8]  = '{1'b0, 3'd5, 12'd0,     19'd1,       19'd0};
      vecs[9]  = '{1'b0, 3'd0, 12'hFFF,   19'h7FFFF,   19'h00FFE};
      vecs[10] = '{1'b1, 3'd0, 12'd5,     19'd10,      19'd15};
      vecs[0].b = 19'd10;

      rst = 1'b1;
      {req0, req1, q_req0, q_req1} = '0;
      {op0, op1, q_op0, q_op1} = '0;
      {a0, a1, q_a0, q_a1} = '0;
      {b0, b1, q_b0, q_b1} = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pulses", {28'b0, gnt0, gnt1, done0, done1}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_alu", {17'b0, alu_op, alu_a}, 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
`ifdef ALU_FLAGS_EN
      chk("rst_flags", {30'b0, z, z1}, 32'd1);
`endif

      // Contention from reset, each port holds until its own grant.
      @(posedge clk); #1;
      req0 = 1'b1; op0 = 3'd2; a0 = 12'd1; b0 = 19'd0;
      req1 = 1'b1; op1 = 3'd6; a1 = 12'd0; b1 = 19'd3;
      e.port = 1'b0; e.res = 19'h7FFFF; sbq.push_back(e);
      e.port = 1'b1; e.res = 19'd6;     sbq.push_back(e);
      g0c = -1; g1c = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (gnt0 && g0c < 0) g0c = c;
         if (gnt1 && g1c < 0) g1c = c;
         @(posedge clk); #1;
         if (g0c >= 0) req0 = 1'b0;
         if (g1c >= 0) req1 = 1'b0;
      end
      chk("cont_gnt0_cycle", g0c, 32'd1);
      chk("cont_gnt1_cycle", g1c, 32'd3);

      // Both held continuously: grants alternate 0,1,0,1.
      @(posedge clk); #1;
      req0 = 1'b1; op0 = 3'd0; a0 = 12'd1; b0 = 19'd2;
      req1 = 1'b1; op1 = 3'd3; a1 = 12'd0; b1 = 19'd5;
      for (int k = 0; k < 4; k++) begin
         e.port = k[0]; e.res = k[0] ? 19'd7 : 19'd3; sbq.push_back(e);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("alt_gnt", {30'b0, gnt0, gnt1},
             (c == 1 || c == 5) ? 32'd2 : (c == 3 || c == 7) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 11; i++)
         do_txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Reset landing on the grant cycle discards the pending completion.
      @(posedge clk); #1;
      req0 = 1'b1; op0 = 3'd1; a0 = 12'd256; b0 = 19'd0;
      gc = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (gnt0) begin gc = c; break; end
      end
      chk("rst_exec_gnt", gc, 32'd1);
      rst = 1'b1; req0 = 1'b0;
      @(negedge clk);
      chk("rst_exec_done", {30'b0, done0, done1}, 32'd0);
      chk("rst_exec_res", 32'(res), 32'd0);
      chk("rst_exec_busy", 32'(busy), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_quiet", {28'b0, gnt0, gnt1, done0, done1}, 32'd0);
      do_txn(1'b0, 3'd1, 12'd256, 19'd0, 19'd16);

      // Fixed priority: port 1 starves while port 0 keeps requesting.
      @(posedge clk); #1;
      q_req0 = 1'b1; q_op0 = 3'd0; q_a0 = 12'd2; q_b0 = 19'd3;
      q_req1 = 1'b1; q_op1 = 3'd5; q_a1 = 12'd0; q_b1 = 19'd9;
      ng0 = 0; ng1 = 0; nd0 = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         ng0 += int'(q_gnt0);
         ng1 += int'(q_gnt1);
         if (q_done0) begin
            nd0++;
            chk("prio_res0", 32'(q_res), 32'd5);
         end
      end
      chk("prio_gnt0_count", ng0, 32'd4);
      chk("prio_gnt1_count", ng1, 32'd0);
      chk("prio_done0_count", nd0, 32'd3);
      @(posedge clk); #1 q_req0 = 1'b0;
      gc = -1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (q_gnt1) begin gc = c; break; end
      end
      chk("prio_gnt1_after_drop", gc, 32'd1);
      @(posedge clk); #1 q_req1 = 1'b0;
      @(negedge clk);
      chk("prio_done1", 32'(q_done1), 32'd1);
      chk("prio_res1", 32'(q_res), 32'd8);

      repeat (3) @(negedge clk);
      chk("sb_empty", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
